// File: rtl/icap_sched.sv
// Two-requester round-robin scheduler for the ICAP path: grant lands 1 cycle after req, beats pass
// through combinationally in STREAM (ICAP-side ready drives buffer-side ready directly), one ack per job.
module icap_sched #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       grant,
  output logic [1:0]       ack,
  output logic [1:0]       status,
  output logic             busy,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  input  logic             icap_done,
  input  logic             icap_err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESP} state_t;

  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_t           state, state_nx;
  logic [1:0]       grant_q, grant_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [15:0]      wcnt, wcnt_nx;
  logic [1:0]       status_q, status_nx;
  logic             prio, prio_nx;
  logic             win;
  logic [LEN_W-1:0] win_len;
  logic             beat;

  // prio names the requester that wins a tie; a lone request always wins
  assign win     = (req == 2'b11) ? prio : req[1];
  assign win_len = win ? req_len1 : req_len0;
  assign beat    = (state == STREAM) && s_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= 2'b00;
      cnt      <= '0;
      wcnt     <= '0;
      status_q <= 2'd0;
      prio     <= 1'b0;
    end else begin
      state    <= state_nx;
      grant_q  <= grant_nx;
      cnt      <= cnt_nx;
      wcnt     <= wcnt_nx;
      status_q <= status_nx;
      prio     <= prio_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant_q;
    cnt_nx    = cnt;
    wcnt_nx   = wcnt;
    status_nx = status_q;
    prio_nx   = prio;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_nx  = win ? 2'b10 : 2'b01;
          cnt_nx    = win_len;
          status_nx = 2'd0;
          if (win_len == '0) begin
            status_nx = 2'd3;
            state_nx  = RESP;
          end else begin
            state_nx  = STREAM;
          end
        end
      end
      STREAM: begin
        if (beat) begin
          cnt_nx = cnt - ONE;
          if (cnt == ONE && s_axis_tlast) begin
            state_nx = WAIT_DONE;
            wcnt_nx  = '0;
          end else if (cnt == ONE || s_axis_tlast) begin
            // length and upstream framing disagree
            state_nx  = RESP;
            status_nx = 2'd3;
          end
        end
      end
      WAIT_DONE: begin
        if (icap_err) begin
          state_nx  = RESP;
          status_nx = 2'd1;
        end else if (icap_done) begin
          state_nx  = RESP;
          status_nx = 2'd0;
        end else if (wcnt == WAIT_LAST) begin
          state_nx  = RESP;
          status_nx = 2'd2;
        end else begin
          wcnt_nx = wcnt + 16'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
        prio_nx  = grant_q[0];
        cnt_nx   = '0;
        wcnt_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign grant         = grant_q;
  assign ack           = (state == RESP) ? grant_q : 2'b00;
  assign status        = (state == RESP) ? status_q : 2'd0;
  assign busy          = (state != IDLE);
  assign m_axis_tvalid = (state == STREAM) && s_axis_tvalid;
  assign s_axis_tready = (state == STREAM) && m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = (state == STREAM) && (cnt == ONE);

endmodule

// File: tb/tb_icap_sched.sv
// Randomized bench for icap_sched: a job-level model predicts grant, beats, ack cycle and status.
module tb_icap_sched;
  localparam int LW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req;
  logic [LW-1:0] req_len0, req_len1;
  logic [1:0]    grant, ack, status;
  logic          busy;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0]   s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0]   m_axis_tdata;
  logic          icap_done, icap_err;

  icap_sched #(.LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .grant(grant), .ack(ack), .status(status), .busy(busy),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .icap_done(icap_done), .icap_err(icap_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // job-level model
  int          rr_next = 0;
  bit          job_on = 0;
  bit          wait_job = 0;
  bit          model_done = 0;
  bit          streaming;
  bit          hs_q = 0;
  int          job_owner, job_len, job_beats, exp_status;
  int          beats = 0;
  int          last_beat_cyc = -1;
  int          exp_ack_cyc = -1;
  int          got_ack_cyc = 0;
  int          got_beats = 0;
  logic [1:0]  got_ack, got_status;

  // upstream source
  logic [31:0] src [0:511];
  int          src_idx = 0;
  int          src_lim = 0;
  int          src_tl = 0;
  bit          src_bp = 0;
  bit          src_rv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // compare process: every non-reset cycle
  always @(negedge clk) begin
    cyc++;
    hs_q = m_axis_tvalid && m_axis_tready;
    if (!reset) begin
      streaming = job_on && (beats < job_beats);
      check("grant", grant, job_on ? (2'b01 << job_owner) : 2'b00);
      check("busy", busy, job_on);
      check("m_valid", m_axis_tvalid, streaming ? s_axis_tvalid : 1'b0);
      check("s_ready", s_axis_tready, streaming ? m_axis_tready : 1'b0);
      if (hs_q && streaming) begin
        check("tdata", m_axis_tdata, src[beats]);
        check("tlast", m_axis_tlast, beats == job_len - 1);
        beats++;
        if (beats == job_beats) begin
          last_beat_cyc = cyc;
          if (!wait_job) exp_ack_cyc = cyc + 1;
        end
      end
      if (job_on && wait_job && beats == job_beats && cyc > last_beat_cyc && exp_ack_cyc < 0) begin
        if (icap_err) begin
          exp_status = 1; exp_ack_cyc = cyc + 1;
        end else if (icap_done) begin
          exp_status = 0; exp_ack_cyc = cyc + 1;
        end else if (cyc - last_beat_cyc == TO) begin
          exp_status = 2; exp_ack_cyc = cyc + 1;
        end
      end
      check("ack", ack, (job_on && cyc == exp_ack_cyc) ? (2'b01 << job_owner) : 2'b00);
      if (job_on && cyc == exp_ack_cyc) begin
        check("status", status, exp_status);
        got_ack     = ack;
        got_status  = status;
        got_beats   = beats;
        got_ack_cyc = cyc;
        rr_next     = 1 - job_owner;
        job_on      = 0;
        model_done  = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hs_q) src_idx++;
  endtask

  task automatic drive_stream();
    s_axis_tvalid = (src_idx < src_lim) && (src_rv ? ($urandom_range(3) != 0) : 1'b1);
    s_axis_tdata  = src[src_idx];
    s_axis_tlast  = (src_idx + 1 == src_tl);
    m_axis_tready = src_bp ? ($urandom_range(2) != 0) : 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_ack"}, ack, 2'b00);
    check({tag, "_status"}, status, 2'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_m_valid"}, m_axis_tvalid, 1'b0);
    check({tag, "_s_ready"}, s_axis_tready, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; icap_done = 1'b0; icap_err = 1'b0;
    tick();
    check_reset_vals("rst");
    job_on = 0; rr_next = 0; reset = 1'b0;
  endtask

  function automatic int winner(input logic [1:0] r);
    return (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : rr_next;
  endfunction

  // mode: 0 no ICAP response, 1 done, 2 done+err, 3 err; raised dly cycles into WAIT_DONE
  task automatic run_job(input logic [1:0] r, input int l0, input int l1, input int tl,
                         input int mode, input int dly, input bit bp, input bit rv,
                         input bit keep, input int abort_at);
    int w, len, guard, wk;
    w   = winner(r);
    len = (w == 1) ? l1 : l0;
    for (int i = 0; i < len + 4; i++) src[i] = $urandom;
    src_idx = 0; src_lim = len + 3; src_tl = tl; src_bp = bp; src_rv = rv;
    req = r; req_len0 = LW'(l0); req_len1 = LW'(l1);
    drive_stream();
    tick();
    job_owner = w; job_len = len; beats = 0; last_beat_cyc = -1; model_done = 0;
    job_beats  = (len == 0) ? 0 : (tl != 0 && tl < len) ? tl : len;
    wait_job   = (len != 0) && (tl == len);
    exp_status = wait_job ? -1 : 3;
    exp_ack_cyc = (len == 0) ? cyc + 1 : -1;
    job_on = 1;
    if (!keep) req = 2'b00;
    guard = 0; wk = -1;
    while (!model_done && guard < 4000 && !(abort_at != 0 && beats >= abort_at)) begin
      drive_stream();
      icap_done = 1'b0; icap_err = 1'b0;
      if (job_on && wait_job && beats == job_beats) begin
        wk++;
        if (mode != 0 && wk == dly) begin
          icap_done = (mode != 3);
          icap_err  = (mode >= 2);
        end
      end
      tick();
      guard++;
    end
    icap_done = 1'b0; icap_err = 1'b0;
    if (abort_at == 0 && !model_done) begin
      check("ack_wait", model_done, 1'b1);
      do_reset();
    end
  endtask

  initial begin
    req = 2'b00; req_len0 = '0; req_len1 = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0; icap_done = 1'b0; icap_err = 1'b0;
    do_reset();

    // single job, done 10 cycles into WAIT_DONE
    run_job(2'b01, 4, 0, 4, 1, 10, 0, 0, 0, 0);
    check("a_ack", got_ack, 2'b01);
    check("a_status", got_status, 2'd0);
    check("a_beats", got_beats, 4);
    check("a_latency", got_ack_cyc - last_beat_cyc, 12);

    // both requesting continuously: strict alternation starting with 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_job(2'b11, 2, 2, 2, 1, 3, 0, 0, 1, 0);
      check("rr_order", got_ack, (i % 2 == 1) ? 2'b10 : 2'b01);
      check("rr_status", got_status, 2'd0);
    end
    req = 2'b00;
    tick();

    // early upstream last, zero length, missing last, late last
    run_job(2'b01, 8, 0, 3, 1, 0, 0, 0, 0, 0);
    check("early_beats", got_beats, 3);
    check("early_status", got_status, 2'd3);
    run_job(2'b10, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    check("zero_ack", got_ack, 2'b10);
    check("zero_status", got_status, 2'd3);
    check("zero_beats", got_beats, 0);
    run_job(2'b01, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    check("nolast_beats", got_beats, 4);
    check("nolast_status", got_status, 2'd3);
    run_job(2'b10, 0, 3, 5, 1, 0, 0, 0, 0, 0);
    check("latelast_beats", got_beats, 3);
    check("latelast_status", got_status, 2'd3);

    // timeout, then err+done together
    run_job(2'b01, 2, 0, 2, 0, 0, 0, 0, 0, 0);
    check("to_status", got_status, 2'd2);
    check("to_latency", got_ack_cyc - last_beat_cyc, TO + 1);
    run_job(2'b01, 2, 0, 2, 2, 5, 0, 0, 0, 0);
    check("err_status", got_status, 2'd1);
    check("err_latency", got_ack_cyc - last_beat_cyc, 7);

    // long job under random backpressure on both sides
    run_job(2'b10, 0, 100, 100, 1, 2, 1, 1, 0, 0);
    check("long_beats", got_beats, 100);
    check("long_status", got_status, 2'd0);

    // reset mid-stream after 5 beats
    run_job(2'b01, 20, 0, 20, 1, 2, 0, 0, 0, 5);
    check("abort_beats", beats, 5);
    reset = 1'b1;
    tick();
    check_reset_vals("abort");
    job_on = 0; rr_next = 0; reset = 1'b0;
    run_job(2'b01, 3, 0, 3, 1, 1, 0, 0, 0, 0);
    check("post_abort_ack", got_ack, 2'b01);
    check("post_abort_status", got_status, 2'd0);

    // randomized jobs
    for (int n = 0; n < 30; n++) begin
      logic [1:0] r;
      int l0, l1, wl, tl, pick;
      r  = 2'($urandom_range(3, 1));
      l0 = ($urandom_range(5) == 0) ? 0 : $urandom_range(12, 1);
      l1 = ($urandom_range(5) == 0) ? 0 : $urandom_range(12, 1);
      wl = (winner(r) == 1) ? l1 : l0;
      pick = $urandom_range(3);
      tl = (pick <= 1) ? wl : $urandom_range(wl + 2);
      run_job(r, l0, l1, tl, $urandom_range(3), $urandom_range(12),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    end
    req = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
